// File: rtl/period_meter_pkg.sv
// ---------------------------------------------------------------------------
// period_meter_pkg
//   Shared types and helpers for the period meter.
//   - state_t       : measurement FSM states (IDLE, MEASURE)
//   - CNT_W_DEFAULT : default counter / output width
//   - sat_inc()     : saturating increment for counters up to 32 bits wide
// ---------------------------------------------------------------------------
package period_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int CNT_W_DEFAULT = 16;

    // Increments cnt and stops at the all-ones value of a width-bit counter.
    // The value is carried in 32 bits so that one helper serves every counter
    // width. Callers cast the result back to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (cnt >= max_val) ? max_val : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
//   Brings an asynchronous level into the clk_in domain through a chain of
//   SYNC_STAGES flops. It then flags the rising and falling edges of the
//   synchronised level. The gesture-input logic also uses this block.
//
//   Ports
//     clk_in  in   system clock, posedge
//     rst_n   in   asynchronous active-low reset (clears the whole chain)
//     d       in   asynchronous input level
//     level   out  synchronised level (last chain stage)
//     rise    out  level is 1 this cycle and was 0 the cycle before
//     fall    out  level is 0 this cycle and was 1 the cycle before
// ---------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   level_d_reg;

    // Stage 0 samples the raw input. Every later stage copies the stage before it.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = d;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg    <= '0;
            level_d_reg <= 1'b0;
        end else begin
            sync_reg    <= sync_next;
            level_d_reg <= level;
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = level & ~level_d_reg;
    assign fall  = ~level & level_d_reg;

endmodule

// File: rtl/period_meter.sv
// ---------------------------------------------------------------------------
// period_meter
//   Measures an asynchronous square wave in clk_in cycles. After the input
//   is acquired, each rising edge reports the number of cycles since the
//   previous rising edge. A missing edge for TIMEOUT_CYC cycles raises a
//   stall flag.
//
//   Build option: define PERIOD_METER_HIGH_TIME_EN to also measure the
//   high time. Without it, high_out is tied to 0.
//
//   Parameters
//     CNT_W        counter/output width (up to 32)
//     TIMEOUT_CYC  cycles without a rising edge before stall (2..2**CNT_W-1)
//     SYNC_STAGES  synchroniser depth on sig_in (>= 2)
//
//   Ports
//     clk_in      in   system clock, posedge
//     rst_n       in   asynchronous active-low reset
//     sig_in      in   asynchronous square wave
//     period_out  out  last measured period in clk_in cycles
//     high_out    out  last measured high time (0 unless high time enabled)
//     meas_valid  out  one-cycle pulse when period_out/high_out update
//     stalled     out  level: no rising edge for TIMEOUT_CYC cycles
// ---------------------------------------------------------------------------
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int TIMEOUT_CYC = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             stalled
);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    logic             level;
    logic             rise;
    logic             fall;
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_inc;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .d     (sig_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign cnt_inc = CNT_W'(sat_inc(32'(cnt_reg), CNT_W));

    // The counter loads 1 on the edge that starts a period. After N cycles
    // it therefore holds N when the next rising edge arrives. A rising edge
    // is tested before the timeout, so an edge that arrives exactly at
    // TIMEOUT_CYC still counts as a valid measurement.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            period_out <= '0;
            meas_valid <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // The first edge only starts timing. The partial
                    // period before it is meaningless and is dropped.
                    if (rise) begin
                        cnt_reg   <= CNT_ONE;
                        state_reg <= MEASURE;
                    end else begin
                        cnt_reg <= '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_out <= cnt_reg;
                        meas_valid <= 1'b1;
                        stalled    <= 1'b0;
                        cnt_reg    <= CNT_ONE;
                    end else if (cnt_reg == TIMEOUT_VAL) begin
                        // The last results stay on the outputs. stalled
                        // remains set until a full period is measured again.
                        stalled   <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef PERIOD_METER_HIGH_TIME_EN
    logic [CNT_W-1:0] hcnt_reg;
    logic [CNT_W-1:0] hcnt_inc;
    logic [CNT_W-1:0] hi_lat_reg;
    logic             fall_seen_reg;

    assign hcnt_inc = CNT_W'(sat_inc(32'(hcnt_reg), CNT_W));

    // The high-time counter runs whatever the FSM state is. A period that
    // starts in IDLE therefore still has its high phase timed. fall_seen_reg
    // records whether the current period saw a falling edge. Without one,
    // the whole period is reported as high time.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_reg      <= '0;
            hi_lat_reg    <= '0;
            fall_seen_reg <= 1'b0;
            high_out      <= '0;
        end else begin
            if (rise) begin
                hcnt_reg      <= CNT_ONE;
                fall_seen_reg <= 1'b0;
            end else if (level) begin
                hcnt_reg <= hcnt_inc;
            end

            if (fall) begin
                hi_lat_reg    <= hcnt_reg;
                fall_seen_reg <= 1'b1;
            end

            // Updates in the same cycle as period_out.
            if (rise && (state_reg == MEASURE)) begin
                high_out <= fall_seen_reg ? hi_lat_reg : cnt_reg;
            end
        end
    end
`else
    logic unused_hi;

    assign high_out  = '0;
    assign unused_hi = level ^ fall;
`endif

endmodule
